// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller:
// length codes, FSM states and request-owner codes.
package mem_ctrl_pkg;

  localparam logic [2:0] LEN_B = 3'b001;
  localparam logic [2:0] LEN_H = 3'b010;
  localparam logic [2:0] LEN_W = 3'b100;

  localparam logic [1:0] IO_TAG_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_ctrl.sv
// Single-port memory controller: arbitrates IF and MEM requests and serialises
// 1/2/4-byte accesses onto an 8-bit RAM bus with little-endian assembly.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_TAG = IO_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_require_i,
  input  logic [31:0] if_addr_i,
  output logic        if_busy_o,
  output logic        if_enable_o,
  output logic [31:0] if_data_o,
  input  logic        mem_require_i,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  mem_length_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_busy_o,
  output logic        mem_enable_o,
  output logic [31:0] mem_data_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  ram_dout_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  input  logic        io_buffer_full_i
);

  state_t      state_reg, state_next;
  owner_t      owner_reg;
  logic [31:0] addr_reg, wdata_reg, acc_reg, acc_merged;
  logic [31:0] ram_a_reg, if_data_reg, mem_data_reg;
  logic [3:0]  n_reg, cnt_reg, new_n;
  logic [7:0]  ram_dout_reg;
  logic        ram_wr_reg, if_enable_reg, mem_enable_reg;
  logic        mem_blocked, accept_mem, accept_if, finish;
  logic [1:0]  rd_idx;
  logic [31:0] step_addr, new_addr;

  // cnt_reg counts edges since accept; the byte captured now was addressed two edges ago
  assign rd_idx    = cnt_reg[1:0] - 2'd2;
  assign step_addr = addr_reg + {28'd0, cnt_reg};
  assign new_addr  = accept_mem ? mem_addr_i : if_addr_i;
  assign new_n     = !accept_mem ? {1'b0, LEN_W} :
                     (mem_length_i == 3'd0) ? 4'd1 : {1'b0, mem_length_i};

  assign mem_blocked = mem_wr_i && (mem_addr_i[17:16] == IO_TAG) && io_buffer_full_i;

  always_comb begin
    acc_merged = acc_reg;
    acc_merged[{rd_idx, 3'b000} +: 8] = ram_din_i;
  end

  always_comb begin
    state_next = state_reg;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (mem_require_i && !mem_enable_reg && !mem_blocked) begin
          accept_mem = 1'b1;
          state_next = mem_wr_i ? ST_WRITE : ST_READ;
        end else if (if_require_i && !if_enable_reg) begin
          accept_if  = 1'b1;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (cnt_reg == n_reg + 4'd1) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_reg == n_reg) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_IF;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      acc_reg        <= '0;
      n_reg          <= '0;
      cnt_reg        <= '0;
      ram_a_reg      <= '0;
      ram_dout_reg   <= '0;
      ram_wr_reg     <= 1'b0;
      if_data_reg    <= '0;
      mem_data_reg   <= '0;
      if_enable_reg  <= 1'b0;
      mem_enable_reg <= 1'b0;
    end else if (rdy) begin
      state_reg      <= state_next;
      if_enable_reg  <= 1'b0;
      mem_enable_reg <= 1'b0;
      if (accept_mem || accept_if) begin
        owner_reg <= accept_mem ? OWN_MEM : OWN_IF;
        addr_reg  <= new_addr;
        wdata_reg <= mem_data_i;
        n_reg     <= new_n;
        cnt_reg   <= 4'd1;
        acc_reg   <= '0;
        ram_a_reg <= new_addr;
        if (accept_mem && mem_wr_i) begin
          ram_wr_reg   <= 1'b1;
          ram_dout_reg <= mem_data_i[7:0];
        end
      end else if (state_reg == ST_READ) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (cnt_reg < n_reg) ram_a_reg <= step_addr;
        if (finish) begin
          if (owner_reg == OWN_MEM) begin
            mem_data_reg   <= acc_merged;
            mem_enable_reg <= 1'b1;
          end else begin
            if_data_reg   <= acc_merged;
            if_enable_reg <= 1'b1;
          end
        end else if (cnt_reg >= 4'd2) begin
          acc_reg <= acc_merged;
        end
      end else if (state_reg == ST_WRITE) begin
        if (finish) begin
          ram_wr_reg     <= 1'b0;
          mem_enable_reg <= 1'b1;
        end else begin
          ram_a_reg    <= step_addr;
          ram_dout_reg <= wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
          ram_wr_reg   <= 1'b1;
          cnt_reg      <= cnt_reg + 4'd1;
        end
      end
    end
  end

  assign if_busy_o    = (state_reg != ST_IDLE);
  assign mem_busy_o   = (state_reg != ST_IDLE);
  assign if_enable_o  = if_enable_reg;
  assign if_data_o    = if_data_reg;
  assign mem_enable_o = mem_enable_reg;
  assign mem_data_o   = mem_data_reg;
  assign ram_a_o      = ram_a_reg;
  assign ram_dout_o   = ram_dout_reg;
  assign ram_wr_o     = ram_wr_reg & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a two-stage byte RAM model and write log.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_require_i, if_busy_o, if_enable_o;
  logic [31:0] if_addr_i, if_data_o;
  logic        mem_require_i, mem_wr_i, mem_busy_o, mem_enable_o;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [2:0]  mem_length_i;
  logic [7:0]  ram_din_i, ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o, io_buffer_full_i;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram_mem [0:65535];
  logic [39:0] wr_log [$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_require_i(if_require_i), .if_addr_i(if_addr_i), .if_busy_o(if_busy_o),
    .if_enable_o(if_enable_o), .if_data_o(if_data_o),
    .mem_require_i(mem_require_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i),
    .mem_length_i(mem_length_i), .mem_data_i(mem_data_i), .mem_busy_o(mem_busy_o),
    .mem_enable_o(mem_enable_o), .mem_data_o(mem_data_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o),
    .io_buffer_full_i(io_buffer_full_i)
  );

  // address registered at edge k yields its byte for capture at edge k+2
  always @(posedge clk) begin
    if (rdy) ram_din_i <= ram_mem[ram_a_o[15:0]];
    if (ram_wr_o) wr_log.push_back({ram_a_o, ram_dout_o});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] log_at(input int i);
    if (i < wr_log.size()) return wr_log[i];
    return '0;
  endfunction

  task automatic wait_enable(input bit is_if, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (is_if ? if_enable_o : mem_enable_o) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, if_cyc, wr_cyc, mem_cyc, en_cyc, pulses;

  initial begin
    rst = 1'b0; rdy = 1'b1;
    if_require_i = 1'b0; if_addr_i = '0;
    mem_require_i = 1'b0; mem_wr_i = 1'b0; mem_addr_i = '0; mem_length_i = '0; mem_data_i = '0;
    io_buffer_full_i = 1'b0;
    for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
    ram_mem[16'h1000] = 8'h13; ram_mem[16'h1001] = 8'h05;
    ram_mem[16'h1002] = 8'h10; ram_mem[16'h1003] = 8'h00;
    ram_mem[16'h2000] = 8'hF0;
    ram_mem[16'hFFFF] = 8'h34; ram_mem[16'h0000] = 8'h12;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, if_busy_o | mem_busy_o}, 32'd0);
    check("rst_wr", {31'd0, ram_wr_o}, 32'd0);
    check("rst_en", {31'd0, if_enable_o | mem_enable_o}, 32'd0);
    check("rst_a", ram_a_o, 32'd0);
    check("rst_data", if_data_o | mem_data_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // IF fetch
    if_require_i = 1'b1; if_addr_i = 32'h1000;
    @(negedge clk);
    check("if_busy", {31'd0, if_busy_o}, 32'd1);
    check("if_a0", ram_a_o, 32'h1000);
    if_require_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3) check($sformatf("if_a%0d", k), ram_a_o, 32'h1000 + k);
      check($sformatf("if_en%0d", k), {31'd0, if_enable_o}, (k == 5) ? 32'd1 : 32'd0);
    end
    check("if_data", if_data_o, 32'h00100513);
    check("if_busy_done", {31'd0, if_busy_o}, 32'd0);
    @(negedge clk);
    check("if_en_pulse", {31'd0, if_enable_o}, 32'd0);
    $display("txn IF fetch 0x1000 data=0x%08h", if_data_o);

    // collision: MEM LB wins, IF follows
    mem_require_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h2000; mem_length_i = 3'b001;
    if_require_i = 1'b1; if_addr_i = 32'h1000;
    @(negedge clk);
    check("col_mem_a", ram_a_o, 32'h2000);
    mem_require_i = 1'b0;
    @(negedge clk);
    check("col_en_early", {31'd0, mem_enable_o}, 32'd0);
    @(negedge clk);
    check("col_mem_en", {31'd0, mem_enable_o}, 32'd1);
    check("col_mem_data", mem_data_o, 32'h000000F0);
    @(negedge clk);
    check("col_if_busy", {31'd0, if_busy_o}, 32'd1);
    check("col_if_a", ram_a_o, 32'h1000);
    if_require_i = 1'b0;
    wait_enable(1'b1, lat);
    check("col_if_lat", lat, 32'd5);
    check("col_if_data", if_data_o, 32'h00100513);
    $display("txn collision LB=0x%08h then IF=0x%08h", mem_data_o, if_data_o);

    // SH 0xABCD to 0x3001
    @(negedge clk);
    wr_log.delete();
    mem_require_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h3001; mem_length_i = 3'b010;
    mem_data_i = 32'h0000ABCD;
    @(negedge clk);
    check("sh_wr0", {31'd0, ram_wr_o}, 32'd1);
    check("sh_a0", ram_a_o, 32'h3001);
    check("sh_d0", {24'd0, ram_dout_o}, 32'hCD);
    mem_require_i = 1'b0;
    @(negedge clk);
    check("sh_a1", ram_a_o, 32'h3002);
    check("sh_d1", {24'd0, ram_dout_o}, 32'hAB);
    check("sh_en1", {31'd0, mem_enable_o}, 32'd0);
    @(negedge clk);
    check("sh_wr_off", {31'd0, ram_wr_o}, 32'd0);
    check("sh_en", {31'd0, mem_enable_o}, 32'd1);
    check("sh_log_n", wr_log.size(), 32'd2);
    check("sh_log0", log_at(0)[31:0], {24'h003001, 8'hCD});
    check("sh_log1", log_at(1)[31:0], {24'h003002, 8'hAB});
    $display("txn SH 0x3001 writes=%0d", wr_log.size());

    // SB to IO region while buffer full; pending IF goes first
    @(negedge clk);
    wr_log.delete();
    io_buffer_full_i = 1'b1;
    mem_require_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h00030000; mem_length_i = 3'b001;
    mem_data_i = 32'h0000005A;
    if_require_i = 1'b1; if_addr_i = 32'h1000;
    @(negedge clk);
    check("io_if_first", ram_a_o, 32'h1000);
    check("io_no_wr", {31'd0, ram_wr_o}, 32'd0);
    if_require_i = 1'b0;
    if_cyc = -1; wr_cyc = -1; mem_cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) io_buffer_full_i = 1'b0;
      if (if_enable_o) if_cyc = k;
      if (ram_wr_o && wr_cyc < 0) begin
        wr_cyc = k;
        mem_require_i = 1'b0;
      end
      if (mem_enable_o) begin
        mem_cyc = k;
        break;
      end
    end
    mem_require_i = 1'b0;
    check("io_if_cyc", if_cyc, 32'd5);
    check("io_wr_cyc", wr_cyc, 32'd6);
    check("io_en_cyc", mem_cyc, 32'd7);
    check("io_log_n", wr_log.size(), 32'd1);
    check("io_log0", log_at(0)[31:0], {24'h030000, 8'h5A});
    $display("txn SB IO 0x30000 after IF, writes=%0d", wr_log.size());

    // LW with rdy low for two cycles
    @(negedge clk);
    mem_require_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h1000; mem_length_i = 3'b100;
    @(negedge clk);
    mem_require_i = 1'b0;
    en_cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2 || k == 3) begin
        check($sformatf("rdy_a%0d", k), ram_a_o, 32'h1001);
        check($sformatf("rdy_busy%0d", k), {31'd0, mem_busy_o}, 32'd1);
      end
      if (mem_enable_o && en_cyc < 0) en_cyc = k;
      if (k == 1) rdy = 1'b0;
      if (k == 3) rdy = 1'b1;
    end
    check("rdy_en_cyc", en_cyc, 32'd7);
    check("rdy_data", mem_data_o, 32'h00100513);
    $display("txn LW 0x1000 with stall data=0x%08h", mem_data_o);

    // length 0 behaves as one byte
    mem_require_i = 1'b1; mem_wr_i = 1'b0; mem_addr_i = 32'h2000; mem_length_i = 3'b000;
    @(negedge clk);
    mem_require_i = 1'b0;
    wait_enable(1'b0, lat);
    check("len0_lat", lat, 32'd2);
    check("len0_data", mem_data_o, 32'h000000F0);
    $display("txn LEN0 0x2000 data=0x%08h", mem_data_o);

    // address wrap-around
    @(negedge clk);
    mem_require_i = 1'b1; mem_addr_i = 32'hFFFFFFFF; mem_length_i = 3'b010;
    @(negedge clk);
    mem_require_i = 1'b0;
    @(negedge clk);
    check("wrap_a1", ram_a_o, 32'h0);
    wait_enable(1'b0, lat);
    check("wrap_lat", lat, 32'd2);
    check("wrap_data", mem_data_o, 32'h00001234);
    $display("txn LH wrap data=0x%08h", mem_data_o);

    // SW interrupted by reset, with a rdy gating check on the strobe
    @(negedge clk);
    mem_require_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 32'h4000; mem_length_i = 3'b100;
    mem_data_i = 32'h11223344;
    @(negedge clk);
    mem_require_i = 1'b0;
    check("sw_wr0", {31'd0, ram_wr_o}, 32'd1);
    rdy = 1'b0;
    #1;
    check("sw_wr_gated", {31'd0, ram_wr_o}, 32'd0);
    rdy = 1'b1;
    @(negedge clk);
    check("sw_a1", ram_a_o, 32'h4001);
    check("sw_d1", {24'd0, ram_dout_o}, 32'h33);
    rst = 1'b0;
    @(negedge clk);
    check("abort_wr", {31'd0, ram_wr_o}, 32'd0);
    check("abort_busy", {31'd0, mem_busy_o}, 32'd0);
    check("abort_data", mem_data_o, 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_enable_o) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    $display("txn SW 0x4000 aborted by reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
